gemm_stream_mac: RTL and testbench

Parametrised streaming GEMM engine computing R = alpha·(A×B) + beta·C on signed fixed-point matrices. It is the next generation of the team's GEMM accelerator. It adds:
- operand capture at start, so callers may change inputs mid-run;
- a configurable number of parallel MAC lanes that accumulate over K;
- selectable saturating or wrapping output;
- an abort input;
- a valid/ready result stream with row/column tags, replacing a full output matrix.

---
 rtl/gemm_stream_mac_if.sv | 24 ++
 rtl/gemm_stream_mac.sv | 210 +++++++++++++++++++++
 tb/tb_gemm_stream_mac.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gemm_stream_mac_if.sv
// rtl/gemm_stream_mac_if.sv - result stream bundle for gemm_stream_mac
// Signals:
//   ovalid  result element valid (driven by master)
//   iready  downstream accepts element (driven by slave)
//   odata   result element, DATA_WIDTH bits, signed
//   orow    row index of odata
//   ocol    column index of odata
interface gemm_stream_mac_if #(
    parameter int DATA_WIDTH    = 16,
    parameter int MATRIX_HEIGHT = 4,
    parameter int MATRIX_WIDTH  = 4
);
    localparam int ROW_W = (MATRIX_HEIGHT > 1) ? $clog2(MATRIX_HEIGHT) : 1;
    localparam int COL_W = (MATRIX_WIDTH > 1) ? $clog2(MATRIX_WIDTH) : 1;

    logic                  ovalid;
    logic                  iready;
    logic [DATA_WIDTH-1:0] odata;
    logic [ROW_W-1:0]      orow;
    logic [COL_W-1:0]      ocol;

    modport master (output ovalid, output odata, output orow, output ocol, input iready);
    modport slave  (input ovalid, input odata, input orow, input ocol, output iready);
endinterface

// File: rtl/gemm_stream_mac.sv
// rtl/gemm_stream_mac.sv - streaming GEMM engine R = alpha*(A x B) + beta*C
// Ports:
//   iclk, irst        clock, synchronous active-high reset
//   istart            start request, honoured only in IDLE
//   iabort            abandon the current job (any non-IDLE state)
//   isat              1 = saturate result, 0 = wrap
//   ialpha, ibeta     signed scalars
//   ia_flat           A (M x K), element (r,k) at [(r*K+k)*DW +: DW]
//   ib_flat           B (K x N), element (k,c) at [(k*N+c)*DW +: DW]
//   ic_flat           C (M x N), element (r,c) at [(r*N+c)*DW +: DW]
//   res               result stream (ovalid/iready/odata/orow/ocol), row-major
//   obusy             high in every state except IDLE
//   odone             one-cycle pulse at job completion
module gemm_stream_mac #(
    parameter int DATA_WIDTH    = 16,
    parameter int MATRIX_HEIGHT = 4,
    parameter int MATRIX_WIDTH  = 4,
    parameter int MATRIX_K      = 4,
    parameter int MAC_LANES     = 2
) (
    input  logic                                            iclk,
    input  logic                                            irst,
    input  logic                                            istart,
    input  logic                                            iabort,
    input  logic                                            isat,
    input  logic [DATA_WIDTH-1:0]                           ialpha,
    input  logic [DATA_WIDTH-1:0]                           ibeta,
    input  logic [MATRIX_HEIGHT*MATRIX_K*DATA_WIDTH-1:0]    ia_flat,
    input  logic [MATRIX_K*MATRIX_WIDTH*DATA_WIDTH-1:0]     ib_flat,
    input  logic [MATRIX_HEIGHT*MATRIX_WIDTH*DATA_WIDTH-1:0] ic_flat,
    gemm_stream_mac_if.master                               res,
    output logic                                            obusy,
    output logic                                            odone
);
    localparam int DW      = DATA_WIDTH;
    localparam int K_STEPS = (MATRIX_K + MAC_LANES - 1) / MAC_LANES;
    localparam int ACC_W   = 2 * DW + $clog2(MATRIX_K) + 1;
    // alpha*acc needs DW+ACC_W bits, beta*C needs 2*DW; one more bit for the sum
    localparam int Y_W     = DW + ACC_W + 1;
    localparam int ROW_W   = (MATRIX_HEIGHT > 1) ? $clog2(MATRIX_HEIGHT) : 1;
    localparam int COL_W   = (MATRIX_WIDTH > 1) ? $clog2(MATRIX_WIDTH) : 1;
    localparam int K_IDX_W = (MATRIX_K > 1) ? $clog2(MATRIX_K) : 1;
    localparam int STEP_W  = (K_STEPS > 1) ? $clog2(K_STEPS) : 1;

    localparam logic signed [Y_W-1:0] SAT_MAX = {{(Y_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [Y_W-1:0] SAT_MIN = ~SAT_MAX;
    localparam logic [DW-1:0] OUT_MAX = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0] OUT_MIN = {1'b1, {(DW-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_MAC,
        S_SCALE,
        S_OUT,
        S_DONE
    } state_t;

    state_t state;

    // Operands captured at start so the caller may change inputs mid-run
    logic signed [DW-1:0] a_q [MATRIX_HEIGHT][MATRIX_K];
    logic signed [DW-1:0] b_q [MATRIX_K][MATRIX_WIDTH];
    logic signed [DW-1:0] c_q [MATRIX_HEIGHT][MATRIX_WIDTH];
    logic signed [DW-1:0] alpha_q;
    logic signed [DW-1:0] beta_q;
    logic                 sat_q;

    logic [ROW_W-1:0]        r_idx;
    logic [COL_W-1:0]        c_idx;
    logic [STEP_W-1:0]       step;
    logic signed [ACC_W-1:0] acc;

    logic signed [ACC_W-1:0]  lane_sum;
    logic signed [2*DW-1:0]   lane_prod;
    logic [K_IDX_W-1:0]       kidx;
    logic signed [Y_W-1:0]    y_full;
    logic [DW-1:0]            y_out;

    always_ff @(posedge iclk) begin
        if (state == S_IDLE && istart) begin
            for (int i = 0; i < MATRIX_HEIGHT; i++) begin
                for (int j = 0; j < MATRIX_K; j++) begin
                    a_q[i][j] <= ia_flat[(i*MATRIX_K+j)*DW +: DW];
                end
            end
            for (int i = 0; i < MATRIX_K; i++) begin
                for (int j = 0; j < MATRIX_WIDTH; j++) begin
                    b_q[i][j] <= ib_flat[(i*MATRIX_WIDTH+j)*DW +: DW];
                end
            end
            for (int i = 0; i < MATRIX_HEIGHT; i++) begin
                for (int j = 0; j < MATRIX_WIDTH; j++) begin
                    c_q[i][j] <= ic_flat[(i*MATRIX_WIDTH+j)*DW +: DW];
                end
            end
            alpha_q <= ialpha;
            beta_q  <= ibeta;
            sat_q   <= isat;
        end
    end

    // Lanes whose k index falls past K (last step when L does not divide K)
    // contribute nothing
    always_comb begin
        lane_sum  = '0;
        lane_prod = '0;
        kidx      = '0;
        for (int l = 0; l < MAC_LANES; l++) begin
            if (int'(step) * MAC_LANES + l < MATRIX_K) begin
                kidx      = K_IDX_W'(int'(step) * MAC_LANES + l);
                lane_prod = a_q[r_idx][kidx] * b_q[kidx][c_idx];
                lane_sum  = lane_sum + ACC_W'(lane_prod);
            end
        end
    end

    always_comb begin
        y_full = Y_W'(alpha_q) * Y_W'(acc) + Y_W'(beta_q) * Y_W'(c_q[r_idx][c_idx]);
        y_out  = y_full[DW-1:0];
        if (sat_q) begin
            if (y_full > SAT_MAX) begin
                y_out = OUT_MAX;
            end else if (y_full < SAT_MIN) begin
                y_out = OUT_MIN;
            end
        end
    end

    always_ff @(posedge iclk) begin
        if (irst) begin
            state      <= S_IDLE;
            r_idx      <= '0;
            c_idx      <= '0;
            step       <= '0;
            acc        <= '0;
            res.ovalid <= 1'b0;
            res.odata  <= '0;
            res.orow   <= '0;
            res.ocol   <= '0;
            obusy      <= 1'b0;
            odone      <= 1'b0;
        end else if (iabort && state != S_IDLE) begin
            state      <= S_IDLE;
            res.ovalid <= 1'b0;
            obusy      <= 1'b0;
            odone      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    odone <= 1'b0;
                    if (istart) begin
                        r_idx <= '0;
                        c_idx <= '0;
                        step  <= '0;
                        acc   <= '0;
                        obusy <= 1'b1;
                        state <= S_MAC;
                    end
                end
                S_MAC: begin
                    acc <= acc + lane_sum;
                    if (step == STEP_W'(K_STEPS - 1)) begin
                        step  <= '0;
                        state <= S_SCALE;
                    end else begin
                        step <= step + 1'b1;
                    end
                end
                S_SCALE: begin
                    res.odata  <= y_out;
                    res.orow   <= r_idx;
                    res.ocol   <= c_idx;
                    res.ovalid <= 1'b1;
                    state      <= S_OUT;
                end
                S_OUT: begin
                    if (res.iready) begin
                        res.ovalid <= 1'b0;
                        if (r_idx == ROW_W'(MATRIX_HEIGHT - 1) &&
                            c_idx == COL_W'(MATRIX_WIDTH - 1)) begin
                            odone <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            if (c_idx == COL_W'(MATRIX_WIDTH - 1)) begin
                                c_idx <= '0;
                                r_idx <= r_idx + 1'b1;
                            end else begin
                                c_idx <= c_idx + 1'b1;
                            end
                            acc   <= '0;
                            step  <= '0;
                            state <= S_MAC;
                        end
                    end
                end
                S_DONE: begin
                    odone <= 1'b0;
                    obusy <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state      <= S_IDLE;
                    res.ovalid <= 1'b0;
                    obusy      <= 1'b0;
                    odone      <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_gemm_stream_mac.sv
// tb/tb_gemm_stream_mac.sv - scoreboard bench for gemm_stream_mac (K=4 and K=3 instances)
module tb_gemm_stream_mac;
    logic iclk = 1'b0;
    always #5 iclk = ~iclk;

    logic irst, start, iabort, isat, sel3, iready;
    logic signed [15:0] alpha, beta;
    logic signed [15:0] am [4][4];
    logic signed [15:0] bm [4][4];
    logic signed [15:0] cm [4][4];
    logic [255:0] a4, b4, cf;
    logic [191:0] a3, b3;
    logic busy4, done4, busy3, done3;

    gemm_stream_mac_if #(.DATA_WIDTH(16), .MATRIX_HEIGHT(4), .MATRIX_WIDTH(4)) s4 ();
    gemm_stream_mac_if #(.DATA_WIDTH(16), .MATRIX_HEIGHT(4), .MATRIX_WIDTH(4)) s3 ();
    assign s4.iready = iready;
    assign s3.iready = iready;

    gemm_stream_mac #(.DATA_WIDTH(16), .MATRIX_HEIGHT(4), .MATRIX_WIDTH(4),
                      .MATRIX_K(4), .MAC_LANES(2)) u_k4 (
        .iclk(iclk), .irst(irst), .istart(start & ~sel3), .iabort(iabort), .isat(isat),
        .ialpha(alpha), .ibeta(beta), .ia_flat(a4), .ib_flat(b4), .ic_flat(cf),
        .res(s4), .obusy(busy4), .odone(done4));

    gemm_stream_mac #(.DATA_WIDTH(16), .MATRIX_HEIGHT(4), .MATRIX_WIDTH(4),
                      .MATRIX_K(3), .MAC_LANES(2)) u_k3 (
        .iclk(iclk), .irst(irst), .istart(start & sel3), .iabort(iabort), .isat(isat),
        .ialpha(alpha), .ibeta(beta), .ia_flat(a3), .ib_flat(b3), .ic_flat(cf),
        .res(s3), .obusy(busy3), .odone(done3));

    logic        mon_valid, mon_busy, mon_done;
    logic [15:0] mon_data;
    logic [1:0]  mon_row, mon_col;
    assign mon_valid = sel3 ? s3.ovalid : s4.ovalid;
    assign mon_data  = sel3 ? s3.odata  : s4.odata;
    assign mon_row   = sel3 ? s3.orow   : s4.orow;
    assign mon_col   = sel3 ? s3.ocol   : s4.ocol;
    assign mon_busy  = sel3 ? busy3     : busy4;
    assign mon_done  = sel3 ? done3     : done4;

    always_comb begin
        a4 = '0; b4 = '0; cf = '0; a3 = '0; b3 = '0;
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 4; k++) begin
                a4[(r*4+k)*16 +: 16] = am[r][k];
                b4[(r*4+k)*16 +: 16] = bm[r][k];
                cf[(r*4+k)*16 +: 16] = cm[r][k];
                if (k < 3) a3[(r*3+k)*16 +: 16] = am[r][k];
                if (r < 3) b3[(r*4+k)*16 +: 16] = bm[r][k];
            end
        end
    end

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [1:0]  r;
        logic [1:0]  c;
        logic [15:0] d;
    } exp_t;
    exp_t q[$];

    function automatic logic [15:0] model(int r, int c, int kd);
        longint acc, y;
        acc = 0;
        for (int k = 0; k < kd; k++) acc += longint'(am[r][k]) * longint'(bm[k][c]);
        y = longint'(alpha) * acc + longint'(beta) * longint'(cm[r][c]);
        if (isat) begin
            if (y > 32767) y = 32767;
            if (y < -32768) y = -32768;
        end
        return y[15:0];
    endfunction

    task automatic set_ident(input int al, input int be, input int cv, input bit sat);
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 4; k++) begin
                am[r][k] = (r == k) ? 16'sd1 : 16'sd0;
                bm[r][k] = 16'(4 * r + k);
                cm[r][k] = 16'(cv);
            end
        end
        alpha = 16'(al); beta = 16'(be); isat = sat;
    endtask

    task automatic set_random(input bit sat);
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 4; k++) begin
                am[r][k] = 16'($urandom); bm[r][k] = 16'($urandom); cm[r][k] = 16'($urandom);
            end
        end
        alpha = 16'($urandom); beta = 16'($urandom); isat = sat;
    endtask

    // Runs one job on the selected instance; expected elements are queued at start
    task automatic run_job(input string name, input int ready_pct, input bit check_timing,
                           input bit perturb);
        int hs = 0, first_v = -1, done_c = -1, kd;
        bit stalled = 0;
        exp_t e, held;
        kd = sel3 ? 3 : 4;
        @(negedge iclk);
        q.delete();
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                e.r = 2'(r); e.c = 2'(c); e.d = model(r, c, kd);
                q.push_back(e);
            end
        end
        start = 1'b1;
        for (int cyc = 1; cyc <= 400 && done_c < 0; cyc++) begin
            @(negedge iclk);
            if (cyc == 1) begin
                start = 1'b0;
                if (perturb) set_random(~isat);
            end
            if (perturb && cyc == 10) start = 1'b1;
            if (perturb && cyc == 11) start = 1'b0;
            iready = ($urandom_range(99) < ready_pct);
            checks++;
            if (mon_valid && mon_done) begin
                failures++;
                $display("FAIL %s valid_with_done cyc=%0d", name, cyc);
            end
            if (stalled) begin
                checks++;
                if (mon_valid !== 1'b1 || {mon_row, mon_col, mon_data} !== held) begin
                    failures++;
                    $display("FAIL %s stall_hold cyc=%0d got v=%0b %h expected v=1 %h",
                             name, cyc, mon_valid, {mon_row, mon_col, mon_data}, held);
                end
            end
            if (mon_valid) begin
                if (first_v < 0) first_v = cyc;
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL %s extra_element got %h expected none", name, mon_data);
                end else begin
                    e = q[0];
                    if (mon_data !== e.d || mon_row !== e.r || mon_col !== e.c) begin
                        failures++;
                        $display("FAIL %s element got r=%0d c=%0d d=%h expected r=%0d c=%0d d=%h",
                                 name, mon_row, mon_col, mon_data, e.r, e.c, e.d);
                    end
                    if (iready) begin
                        void'(q.pop_front());
                        hs++;
                    end
                end
            end
            stalled = mon_valid && !iready;
            held = {mon_row, mon_col, mon_data};
            if (mon_done) done_c = cyc;
        end
        checks++;
        if (hs != 16 || q.size() != 0) begin
            failures++;
            $display("FAIL %s handshakes got %0d left=%0d expected 16 left=0", name, hs, q.size());
        end
        checks++;
        if (done_c < 0) begin
            failures++;
            $display("FAIL %s odone_timeout got none expected pulse", name);
        end
        if (check_timing) begin
            checks++;
            if (first_v != 4 || done_c != 65) begin
                failures++;
                $display("FAIL %s timing got first_valid=%0d done=%0d expected 4 65",
                         name, first_v, done_c);
            end
        end
        @(negedge iclk);
        checks++;
        if (mon_busy !== 1'b0 || mon_valid !== 1'b0 || mon_done !== 1'b0) begin
            failures++;
            $display("FAIL %s after_done got busy=%0b valid=%0b done=%0b expected 0 0 0",
                     name, mon_busy, mon_valid, mon_done);
        end
        if (perturb) begin
            bit active = 0;
            repeat (10) begin
                @(negedge iclk);
                if (mon_valid || mon_busy) active = 1;
            end
            checks++;
            if (active) begin
                failures++;
                $display("FAIL %s busy_start_ignored got activity=1 expected 0", name);
            end
        end
    endtask

    task automatic test_reset();
        irst = 1'b1;
        repeat (3) @(negedge iclk);
        irst = 1'b0;
        checks++;
        if (s4.ovalid !== 1'b0) begin failures++; $display("FAIL reset_ovalid got %b expected 0", s4.ovalid); end
        checks++;
        if (s4.odata !== 16'h0) begin failures++; $display("FAIL reset_odata got %h expected 0", s4.odata); end
        checks++;
        if (s4.orow !== 2'd0 || s4.ocol !== 2'd0) begin
            failures++; $display("FAIL reset_tags got %0d %0d expected 0 0", s4.orow, s4.ocol);
        end
        checks++;
        if (busy4 !== 1'b0 || done4 !== 1'b0) begin
            failures++; $display("FAIL reset_busy_done got %b %b expected 0 0", busy4, done4);
        end
        checks++;
        if (s3.ovalid !== 1'b0 || busy3 !== 1'b0 || done3 !== 1'b0) begin
            failures++; $display("FAIL reset_k3 got %b %b %b expected 0 0 0", s3.ovalid, busy3, done3);
        end
    endtask

    task automatic test_identity();
        sel3 = 1'b0; set_ident(1, 0, 0, 1'b0);
        run_job("identity", 100, 1'b1, 1'b0);
    endtask

    task automatic test_scaled_capture();
        sel3 = 1'b0; set_ident(2, 3, 5, 1'b0);
        run_job("scaled_capture", 100, 1'b1, 1'b1);
    endtask

    task automatic test_saturation();
        sel3 = 1'b0;
        for (bit s = 1'b1; ; s = 1'b0) begin
            for (int r = 0; r < 4; r++) begin
                for (int k = 0; k < 4; k++) begin
                    am[r][k] = 16'h7FFF; bm[r][k] = 16'h7FFF; cm[r][k] = 16'h0;
                end
            end
            alpha = 16'h7FFF; beta = 16'h0; isat = s;
            run_job(s ? "saturate" : "wrap", 100, 1'b1, 1'b0);
            if (!s) break;
        end
    endtask

    task automatic test_backpressure();
        sel3 = 1'b0; set_ident(2, 3, 5, 1'b0);
        run_job("backpressure", 50, 1'b0, 1'b0);
        set_random(1'b1);
        run_job("backpressure_rand", 50, 1'b0, 1'b0);
    endtask

    task automatic test_k3();
        sel3 = 1'b1;
        set_random(1'b0);
        run_job("k3_wrap", 100, 1'b1, 1'b0);
        set_random(1'b1);
        run_job("k3_sat_bp", 60, 1'b0, 1'b0);
        sel3 = 1'b0;
    endtask

    task automatic test_abort();
        int hs = 0;
        bit hit = 0, seen = 0;
        sel3 = 1'b0; set_ident(1, 0, 0, 1'b0); iready = 1'b1;
        @(negedge iclk);
        start = 1'b1;
        for (int cyc = 1; cyc <= 200 && !hit; cyc++) begin
            @(negedge iclk);
            start = 1'b0;
            if (mon_valid && hs == 4) begin
                iabort = 1'b1; iready = 1'b0; hit = 1;
            end else if (mon_valid && iready) begin
                hs++;
            end
        end
        checks++;
        if (!hit) begin failures++; $display("FAIL abort_reach got none expected element 5"); end
        @(negedge iclk);
        iabort = 1'b0; iready = 1'b1;
        checks++;
        if (mon_valid !== 1'b0 || mon_busy !== 1'b0) begin
            failures++; $display("FAIL abort_drop got valid=%b busy=%b expected 0 0", mon_valid, mon_busy);
        end
        repeat (80) begin
            @(negedge iclk);
            if (mon_done || mon_valid) seen = 1;
        end
        checks++;
        if (seen) begin failures++; $display("FAIL abort_quiet got activity expected none"); end
        run_job("after_abort", 100, 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid();
        bit seen = 0;
        sel3 = 1'b0; set_ident(2, 3, 5, 1'b0);
        @(negedge iclk); start = 1'b1;
        @(negedge iclk); start = 1'b0;
        @(negedge iclk); irst = 1'b1;
        @(negedge iclk); irst = 1'b0;
        checks++;
        if (s4.ovalid !== 1'b0 || busy4 !== 1'b0 || done4 !== 1'b0 ||
            s4.odata !== 16'h0 || s4.orow !== 2'd0 || s4.ocol !== 2'd0) begin
            failures++;
            $display("FAIL reset_mid got v=%b b=%b d=%b data=%h r=%0d c=%0d expected all 0",
                     s4.ovalid, busy4, done4, s4.odata, s4.orow, s4.ocol);
        end
        repeat (80) begin
            @(negedge iclk);
            if (done4 || s4.ovalid) seen = 1;
        end
        checks++;
        if (seen) begin failures++; $display("FAIL reset_mid_quiet got activity expected none"); end
        run_job("after_reset", 100, 1'b1, 1'b0);
    endtask

    initial begin
        irst = 1'b1; start = 1'b0; iabort = 1'b0; iready = 1'b0; sel3 = 1'b0;
        set_ident(1, 0, 0, 1'b0);
        test_reset();
        test_identity();
        test_scaled_capture();
        test_saturation();
        test_backpressure();
        test_k3();
        test_abort();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
